// File: rtl/ternary_pkg.sv
// Shared ternary codec definitions used by both the compress and decompress paths.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  // Two's-complement trit encoding; 2'b10 is never produced.
  localparam trit_t TRIT_NEG  = 2'b11;
  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;

  localparam int unsigned TRITS_PER_BYTE = 5;
  localparam int unsigned CODE_MAX       = 242;

  // Decompressor control: EMPTY holds no word, DRAIN is emitting groups.
  typedef enum logic {
    StEmpty,
    StDrain
  } dec_state_e;

endpackage

// File: rtl/ternary_decompress_if.sv
// Word-in / trit-group-out stream bundle for the ternary decompressor.
interface ternary_decompress_if #(
  parameter int unsigned NUM_BYTES = 4
);
  localparam int unsigned IDX_WIDTH = $clog2(NUM_BYTES);

  logic [8*NUM_BYTES-1:0] in_data_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [9:0]             out_trits_o;
  logic [IDX_WIDTH-1:0]   out_idx_o;
  logic                   out_last_o;
  logic                   out_invalid_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

  // Decoder side: consumes words, produces trit groups.
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_trits_o, out_idx_o, out_last_o, out_invalid_o, out_valid_o
  );

  // Environment side: produces words, consumes trit groups.
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_trits_o, out_idx_o, out_last_o, out_invalid_o, out_valid_o
  );
endinterface

// File: rtl/ternary_byte_decode.sv
// Combinational base-3 unpack of one byte into five trits, t0 in the low bits.
module ternary_byte_decode
  import ternary_pkg::*;
(
  input  logic [7:0] code,
  output logic [9:0] trits,
  output logic       invalid
);

  logic [7:0] rem;

  // Divide-by-3 chain: each remainder 0/1/2 maps to trit -1/0/+1.
  always_comb begin
    rem     = code;
    trits   = '0;
    invalid = (code > 8'(CODE_MAX));
    for (int i = 0; i < int'(TRITS_PER_BYTE); i++) begin
      unique case (rem % 8'd3)
        8'd0:    trits[2*i +: 2] = TRIT_NEG;
        8'd1:    trits[2*i +: 2] = TRIT_ZERO;
        default: trits[2*i +: 2] = TRIT_POS;
      endcase
      rem = rem / 8'd3;
    end
    if (invalid) trits = '0;
  end

endmodule

// File: rtl/ternary_decompress.sv
// Buffers one packed word and emits its bytes as trit groups, LSB byte first.
module ternary_decompress
  import ternary_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  ternary_decompress_if.slave   bus
);

  localparam int unsigned            IDX_WIDTH = $clog2(NUM_BYTES);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_BYTES - 1);

  dec_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [8*NUM_BYTES-1:0]   buf_q, buf_d;

  logic       full;
  logic       at_last;
  logic       accept;
  logic       group_hs;
  logic [7:0] cur_byte;
  logic [9:0] dec_trits;
  logic       dec_invalid;

  assign full     = (state_q == StDrain);
  assign at_last  = (idx_q == LAST_IDX);
  assign cur_byte = buf_q[{idx_q, 3'b000} +: 8];
  assign group_hs = full && bus.out_ready_i;
  assign accept   = bus.in_valid_i && bus.in_ready_o;

  // Reload is allowed while the last group is being consumed, so words stream with no bubble.
  assign bus.in_ready_o = !clear_i && (!full || (bus.out_ready_i && at_last));

  ternary_byte_decode u_decode (
    .code    (cur_byte),
    .trits   (dec_trits),
    .invalid (dec_invalid)
  );

  // Next-state: clear beats accept beats group advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (clear_i) begin
      state_d = StEmpty;
      idx_d   = '0;
    end else if (accept) begin
      state_d = StDrain;
      idx_d   = '0;
      buf_d   = bus.in_data_i;
    end else if (group_hs) begin
      if (at_last) begin
        state_d = StEmpty;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State, index and word buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Group outputs come from registered state only and read as zero when idle.
  always_comb begin
    bus.out_valid_o   = full;
    bus.out_trits_o   = '0;
    bus.out_idx_o     = '0;
    bus.out_last_o    = 1'b0;
    bus.out_invalid_o = 1'b0;
    if (full) begin
      bus.out_trits_o   = dec_trits;
      bus.out_idx_o     = idx_q;
      bus.out_last_o    = at_last;
      bus.out_invalid_o = dec_invalid;
    end
  end

endmodule

// File: tb/tb_ternary_decompress.sv
// Self-checking bench for ternary_decompress: directed vectors plus a randomized model run.
module tb_ternary_decompress;

  localparam int unsigned NB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  ternary_decompress_if #(.NUM_BYTES(NB)) bus ();

  ternary_decompress #(.NUM_BYTES(NB)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [9:0] trits;
    logic       inv;
  } vec_t;

  vec_t table_v[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_group(input string name, input logic v, input logic [9:0] t,
                              input int idx, input logic last, input logic inv);
    check({name, " valid"},   32'(bus.out_valid_o),   32'(v));
    check({name, " trits"},   32'(bus.out_trits_o),   32'(t));
    check({name, " idx"},     32'(bus.out_idx_o),     32'(idx));
    check({name, " last"},    32'(bus.out_last_o),    32'(last));
    check({name, " invalid"}, 32'(bus.out_invalid_o), 32'(inv));
  endtask

  // Reference: base-3 digits of the byte, each digit d giving trit d-1.
  function automatic logic [10:0] ref_group(input logic [7:0] b);
    int v;
    int d;
    logic [9:0] t;
    t = '0;
    if (int'(b) > 242) return {1'b1, 10'h000};
    v = int'(b);
    for (int i = 0; i < 5; i++) begin
      d = (v % 3) - 1;
      t[2*i +: 2] = 2'(d);
      v = v / 3;
    end
    return {1'b0, t};
  endfunction

  initial begin
    int rem;
    logic [31:0] mword;
    logic [10:0] g;
    logic exp_ready;
    logic [15:0] exp_vec;
    logic [15:0] got_vec;
    int k;

    table_v[0] = '{8'h00, 10'h3FF, 1'b0};
    table_v[1] = '{8'h05, 10'h3F1, 1'b0};
    table_v[2] = '{8'h79, 10'h000, 1'b0};
    table_v[3] = '{8'hF2, 10'h155, 1'b0};
    table_v[4] = '{8'hF3, 10'h000, 1'b1};
    table_v[5] = '{8'hFF, 10'h000, 1'b1};
    table_v[6] = '{8'hB5, 10'h1DC, 1'b0};
    table_v[7] = '{8'h51, 10'h0FF, 1'b0};

    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1 expect_group("reset", 1'b0, 10'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset in_ready", 32'(bus.in_ready_o), 32'd1);

    // Single word with mixed codes including an illegal top byte
    @(negedge clk);
    bus.in_data_i  = 32'hF3F2_7900;
    bus.in_valid_i = 1'b1;
    #1 check("single accept ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1 expect_group("single g0", 1'b1, 10'h3FF, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_group("single g1", 1'b1, 10'h000, 1, 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_group("single g2", 1'b1, 10'h155, 2, 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_group("single g3", 1'b1, 10'h000, 3, 1'b1, 1'b1);
    @(negedge clk);
    #1 expect_group("single done", 1'b0, 10'h0, 0, 1'b0, 1'b0);

    // Table vectors carried in two back-to-back words
    @(negedge clk);
    bus.in_data_i  = {table_v[3].code, table_v[2].code, table_v[1].code, table_v[0].code};
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_data_i  = {table_v[7].code, table_v[6].code, table_v[5].code, table_v[4].code};
      bus.in_valid_i = (i < 4);
      #1;
      expect_group($sformatf("table[%0d]", i), 1'b1, table_v[i].trits, i % 4, (i % 4) == 3,
                   table_v[i].inv);
      check($sformatf("table[%0d] in_ready", i), 32'(bus.in_ready_o), 32'((i % 4) == 3));
    end
    @(negedge clk);
    #1 expect_group("b2b done", 1'b0, 10'h0, 0, 1'b0, 1'b0);

    // Backpressure at idx 1
    @(negedge clk);
    bus.in_data_i  = 32'hF3F2_7900;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1 expect_group("bp g0", 1'b1, 10'h3FF, 0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.in_data_i   = 32'h0505_0505;
      #1 expect_group($sformatf("bp hold%0d", j), 1'b1, 10'h000, 1, 1'b0, 1'b0);
      check($sformatf("bp hold%0d in_ready", j), 32'(bus.in_ready_o), 32'd0);
    end
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b0;
    #1 expect_group("bp release", 1'b1, 10'h000, 1, 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_group("bp g2", 1'b1, 10'h155, 2, 1'b0, 1'b0);

    // Clear at idx 2 with a word offered
    clear           = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'h0505_0505;
    #1 check("clear in_ready", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    clear          = 1'b0;
    bus.in_valid_i = 1'b0;
    #1 expect_group("after clear", 1'b0, 10'h0, 0, 1'b0, 1'b0);
    check("after clear in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    #1 check("clear no accept", 32'(bus.out_valid_o), 32'd0);

    // Asynchronous reset mid-word at idx 1
    @(negedge clk);
    bus.in_data_i  = 32'hF3F2_7900;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    #1 expect_group("pre-reset g1", 1'b1, 10'h000, 1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 expect_group("mid reset", 1'b0, 10'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.in_data_i  = 32'h7979_7979;
    bus.in_valid_i = 1'b1;
    #1 check("post reset ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 expect_group($sformatf("post reset g%0d", i), 1'b1, 10'h000, i, i == 3, 1'b0);
      @(negedge clk);
    end
    #1 check("post reset done", 32'(bus.out_valid_o), 32'd0);

    // Randomized traffic against a word/remaining-groups model
    rem   = 0;
    mword = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.in_valid_i  = 1'($urandom % 2);
      bus.in_data_i   = $urandom;
      bus.out_ready_i = ($urandom % 4) != 0;
      clear           = ($urandom % 32) == 0;
      #1;
      exp_ready = !clear && (rem == 0 || (bus.out_ready_i && rem == 1));
      if (rem > 0) begin
        k = NB - rem;
        g = ref_group(mword[8*k +: 8]);
        exp_vec = {1'b1, g[9:0], 2'(k), k == NB - 1, g[10], exp_ready};
      end else begin
        exp_vec = {1'b0, 10'h000, 2'd0, 1'b0, 1'b0, exp_ready};
      end
      got_vec = {bus.out_valid_o, bus.out_trits_o, bus.out_idx_o, bus.out_last_o,
                 bus.out_invalid_o, bus.in_ready_o};
      check($sformatf("random cycle %0d", c), 32'(got_vec), 32'(exp_vec));
      if (clear) begin
        rem = 0;
      end else if (bus.in_valid_i && exp_ready) begin
        mword = bus.in_data_i;
        rem   = NB;
      end else if (rem > 0 && bus.out_ready_i) begin
        rem = rem - 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
